// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package mux4_arbiter_pkg;

  localparam int unsigned NUM_REQ       = 4;
  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux4to1.sv
// Plain four-way payload multiplexer.
module mux4to1
  import mux4_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    unique case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter over four requesters with a registered, ready/valid output stage.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [WIDTH-1:0]   data3,
  input  logic [WIDTH-1:0]   data4,
  output logic [NUM_REQ-1:0] ack,
  output logic [1:0]         select,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         select_q, select_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic               handshake;
  logic [NUM_REQ-1:0] req_masked;
  logic [1:0]         base;
  logic [1:0]         cand;
  logic [1:0]         grant_idx;
  logic               grant_valid;
  logic [WIDTH-1:0]   mux_data;

  assign handshake = (state_q == BUSY) && out_ready;

  // Arbitration only happens in IDLE or on a handshake; in the latter case the
  // completing requester becomes "last", so the scan starts just past it.
  always_comb begin
    req_masked = req;
    if (handshake) begin
      req_masked[select_q] = 1'b0;
    end
    base        = (state_q == BUSY) ? select_q : last_q;
    cand        = base;
    grant_valid = 1'b0;
    grant_idx   = base;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = base + 2'(i);
      if (!grant_valid && req_masked[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  mux4to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i (grant_idx),
    .d0_i  (data1),
    .d1_i  (data2),
    .d2_i  (data3),
    .d3_i  (data4),
    .y_o   (mux_data)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    select_d = select_q;
    data_d   = data_q;
    ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d  = BUSY;
          select_d = grant_idx;
          data_d   = mux_data;
        end
      end
      BUSY: begin
        if (out_ready) begin
          ack_d[select_q] = 1'b1;
          last_d          = select_q;
          if (grant_valid) begin
            select_d = grant_idx;
            data_d   = mux_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 2'd3;
      select_q <= 2'd0;
      data_q   <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      select_q <= select_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign select    = select_q;
  assign data_out  = data_q;
  assign out_valid = (state_q == BUSY);
  assign busy      = (state_q == BUSY);

endmodule
